// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX register: ALU op codes, control-bundle layout, stage modes.
// The control-bundle bit positions are common to the ID/EX, EX/MEM and MEM/WB registers.
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  localparam int CTL_REG_WRITE  = 0;
  localparam int CTL_MEM_READ   = 1;
  localparam int CTL_MEM_WRITE  = 2;
  localparam int CTL_MEM_TO_REG = 3;
  localparam int CTL_ALU_SRC    = 4;
  localparam int CTL_REG_DST    = 5;
  localparam int CTL_W          = 6;

  // Field order matches the CTL_* bit positions (reg_write is bit 0).
  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic mem_write;
    logic mem_read;
    logic reg_write;
  } ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_FLUSH  = 2'd2,
    MODE_BUBBLE = 2'd3
  } mode_e;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detect: a load in EX whose destination a real ID instruction reads.
// Purely combinational, zero latency; no flow control of its own.
module load_use_detect #(
  parameter int RW = 5
) (
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic          id_use_rs_i,
  input  logic          id_use_rt_i,
  input  logic          id_valid_i,
  input  logic [RW-1:0] ex_rt_i,
  input  logic          ex_mem_read_i,
  input  logic          ex_valid_i,
  output logic          load_use_o
);
  import id_ex_stage_pkg::*;

  logic ex_is_load;
  logic rs_hit;
  logic rt_hit;

  // A load into $0 never produces a value worth waiting for.
  assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rt_i != RW'(REG_ZERO));
  assign rs_hit     = id_use_rs_i & (id_rs_i == ex_rt_i);
  assign rt_hit     = id_use_rt_i & (id_rt_i == ex_rt_i);
  assign load_use_o = ex_is_load & id_valid_i & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and memory-stall hold.
// One-cycle ID->EX latency; pc_write/ifid_write are same-cycle stall outputs.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic [3:0]    id_alu_op,
  input  logic          id_valid,
  input  logic          mem_stall,
  input  logic          flush,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_alu_src,
  output logic          ex_reg_dst,
  output logic [3:0]    ex_alu_op,
  output logic          ex_valid,
  output logic          pc_write,
  output logic          ifid_write,
  output logic [CW-1:0] bubble_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  ctrl_t         ctrl_q, ctrl_d, id_ctrl;
  logic [3:0]    alu_op_q, alu_op_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_use;
  mode_e         mode;

  load_use_detect #(.RW(RW)) u_load_use_detect (
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_use_rs_i   (id_use_rs),
    .id_use_rt_i   (id_use_rt),
    .id_valid_i    (id_valid),
    .ex_rt_i       (rt_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_valid_i    (valid_q),
    .load_use_o    (load_use)
  );

  always_comb begin
    id_ctrl            = '0;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.reg_dst    = id_reg_dst;
  end

  always_comb begin
    mode = MODE_PASS;
    if (mem_stall)     mode = MODE_HOLD;
    else if (flush)    mode = MODE_FLUSH;
    else if (load_use) mode = MODE_BUBBLE;
  end

  // Fetch only advances when ID is not being replayed; reset always lets it run.
  always_comb begin
    pc_write   = rst | (mode == MODE_PASS) | (mode == MODE_FLUSH);
    ifid_write = pc_write;
  end

  always_comb begin
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    alu_op_d  = alu_op_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    case (mode)
      MODE_HOLD: ;
      MODE_FLUSH, MODE_BUBBLE: begin
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        ctrl_d    = '0;
        alu_op_d  = '0;
        valid_d   = 1'b0;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      end
      default: begin
        // An empty ID slot becomes a clean bubble without counting as inserted.
        if (id_valid) begin
          rs_d      = id_rs;
          rt_d      = id_rt;
          rd_d      = id_rd;
          rs_data_d = id_rs_data;
          rt_data_d = id_rt_data;
          imm_d     = id_imm;
          ctrl_d    = id_ctrl;
          alu_op_d  = id_alu_op;
          valid_d   = 1'b1;
        end else begin
          rs_d      = '0;
          rt_d      = '0;
          rd_d      = '0;
          rs_data_d = '0;
          rt_data_d = '0;
          imm_d     = '0;
          ctrl_d    = '0;
          alu_op_d  = '0;
          valid_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      alu_op_q  <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_rs_data    = rs_data_q;
  assign ex_rt_data    = rt_data_q;
  assign ex_imm        = imm_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_alu_op     = alu_op_q;
  assign ex_valid      = valid_q;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for the hazard/flush/stall sequence plus reset and saturation.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          id_use_rs, id_use_rt;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [3:0]    id_alu_op;
  logic          id_valid, mem_stall, flush;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic [3:0]    ex_alu_op;
  logic          ex_valid, pc_write, ifid_write;
  logic [CW-1:0] bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_alu_op(id_alu_op), .id_valid(id_valid), .mem_stall(mem_stall), .flush(flush),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_alu_op(ex_alu_op), .ex_valid(ex_valid), .pc_write(pc_write), .ifid_write(ifid_write),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rs, rt;
    logic          use_rs, use_rt, mr, valid, fl, st;
    logic [DW-1:0] data;
    logic          e_pc, e_valid;
    logic [RW-1:0] e_rs, e_rt;
    logic          e_mr;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                              input logic use_rs, input logic use_rt, input logic mr,
                              input logic valid, input logic fl, input logic st,
                              input logic [DW-1:0] data, input logic e_pc, input logic e_valid,
                              input logic [RW-1:0] e_rs, input logic [RW-1:0] e_rt,
                              input logic e_mr, input logic [DW-1:0] e_data,
                              input logic [CW-1:0] e_cnt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.use_rs = use_rs; v.use_rt = use_rt; v.mr = mr;
    v.valid = valid; v.fl = fl; v.st = st; v.data = data;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_rs = e_rs; v.e_rt = e_rt;
    v.e_mr = e_mr; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic use_rs,
                          input logic use_rt, input logic mr, input logic valid,
                          input logic fl, input logic st, input logic [DW-1:0] data);
    id_rs = rs; id_rt = rt; id_rd = rt + 5'd1;
    id_use_rs = use_rs; id_use_rt = use_rt;
    id_rs_data = data; id_rt_data = ~data; id_imm = data + 32'd4;
    id_reg_write = valid; id_mem_read = mr; id_mem_write = 1'b0;
    id_mem_to_reg = mr; id_alu_src = mr; id_reg_dst = ~mr;
    id_alu_op = 4'd0; id_valid = valid; flush = fl; mem_stall = st;
  endtask

  initial begin
    rst = 1'b1;
    drive_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    #2;
    check("reset ex_valid", 32'(ex_valid), 32'd0);
    check("reset ex_rt_data", ex_rt_data, 32'd0);
    check("reset bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("reset pc_write", 32'(pc_write), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    //                rs     rt     urs   urt   mr    vld   fl    st    data        pc    vld   ers    ert    emr   edata       cnt
    vecs[0]  = mk(5'd1,  5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 5'd1,  5'd8,  1'b1, 32'h100, 4'd0); // lw $8
    vecs[1]  = mk(5'd8,  5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h008, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 32'h000, 4'd1); // add load-use
    vecs[2]  = mk(5'd8,  5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h008, 1'b1, 1'b1, 5'd8,  5'd3,  1'b0, 32'h008, 4'd1); // add replays
    vecs[3]  = mk(5'd2,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h020, 1'b1, 1'b1, 5'd2,  5'd0,  1'b1, 32'h020, 4'd1); // lw $0
    vecs[4]  = mk(5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h030, 1'b1, 1'b1, 5'd0,  5'd0,  1'b0, 32'h030, 4'd1); // reads $0: no stall
    vecs[5]  = mk(5'd5,  5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h040, 1'b1, 1'b1, 5'd5,  5'd4,  1'b1, 32'h040, 4'd1); // lw $4
    vecs[6]  = mk(5'd4,  5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h050, 1'b1, 1'b1, 5'd4,  5'd8,  1'b0, 32'h050, 4'd1); // rs=4 unused
    vecs[7]  = mk(5'd8,  5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h060, 1'b1, 1'b1, 5'd8,  5'd7,  1'b0, 32'h060, 4'd1); // EX not a load
    vecs[8]  = mk(5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0ff, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 32'h000, 4'd1); // empty ID
    vecs[9]  = mk(5'd3,  5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h070, 1'b1, 1'b1, 5'd3,  5'd10, 1'b1, 32'h070, 4'd1); // lw $10
    vecs[10] = mk(5'd10, 5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h075, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 32'h000, 4'd2); // flush+load_use
    vecs[11] = mk(5'd1,  5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h080, 1'b1, 1'b1, 5'd1,  5'd11, 1'b1, 32'h080, 4'd2); // lw $11
    vecs[12] = mk(5'd11, 5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h085, 1'b0, 1'b1, 5'd1,  5'd11, 1'b1, 32'h080, 4'd2); // stall+flush
    vecs[13] = mk(5'd11, 5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h085, 1'b0, 1'b1, 5'd1,  5'd11, 1'b1, 32'h080, 4'd2);
    vecs[14] = mk(5'd11, 5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h085, 1'b0, 1'b1, 5'd1,  5'd11, 1'b1, 32'h080, 4'd2);
    vecs[15] = mk(5'd11, 5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h085, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 32'h000, 4'd3); // flush lands
    vecs[16] = mk(5'd2,  5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h090, 1'b1, 1'b1, 5'd2,  5'd12, 1'b1, 32'h090, 4'd3); // lw $12
    vecs[17] = mk(5'd12, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0a0, 1'b0, 1'b1, 5'd2,  5'd12, 1'b1, 32'h090, 4'd3); // load-use under stall
    vecs[18] = mk(5'd12, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0a0, 1'b0, 1'b1, 5'd2,  5'd12, 1'b1, 32'h090, 4'd3);
    vecs[19] = mk(5'd12, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0a0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 32'h000, 4'd4); // bubble after stall
    vecs[20] = mk(5'd12, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0a0, 1'b1, 1'b1, 5'd12, 5'd0,  1'b0, 32'h0a0, 4'd4); // consumer issues

    for (int i = 0; i < 21; i++) begin
      drive_id(vecs[i].rs, vecs[i].rt, vecs[i].use_rs, vecs[i].use_rt, vecs[i].mr,
               vecs[i].valid, vecs[i].fl, vecs[i].st, vecs[i].data);
      #1;
      check($sformatf("v%0d pc_write", i), 32'(pc_write), 32'(vecs[i].e_pc));
      check($sformatf("v%0d ifid_write", i), 32'(ifid_write), 32'(vecs[i].e_pc));
      @(posedge clk);
      #1;
      check($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d ex_rs", i), 32'(ex_rs), 32'(vecs[i].e_rs));
      check($sformatf("v%0d ex_rt", i), 32'(ex_rt), 32'(vecs[i].e_rt));
      check($sformatf("v%0d ex_mem_read", i), 32'(ex_mem_read), 32'(vecs[i].e_mr));
      check($sformatf("v%0d ex_rs_data", i), ex_rs_data, vecs[i].e_data);
      check($sformatf("v%0d bubble_cnt", i), 32'(bubble_cnt), 32'(vecs[i].e_cnt));
      @(negedge clk);
    end

    // Saturation: counter is at 4, so 11 flushes reach 15 and the rest must not wrap.
    for (int k = 1; k <= 20; k++) begin
      drive_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1);
      @(posedge clk);
      #1;
      check($sformatf("sat flush %0d bubble_cnt", k), 32'(bubble_cnt), (4 + k > 15) ? 32'd15 : 32'(4 + k));
      @(negedge clk);
    end

    // Asynchronous reset between edges with a load sitting in EX.
    drive_id(5'd3, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hdead);
    @(posedge clk);
    #1;
    check("pre-reset ex_rt", 32'(ex_rt), 32'd13);
    #1;
    mem_stall = 1'b1;
    rst = 1'b1;
    #1;
    check("midreset ex_valid", 32'(ex_valid), 32'd0);
    check("midreset ex_rt", 32'(ex_rt), 32'd0);
    check("midreset ex_mem_read", 32'(ex_mem_read), 32'd0);
    check("midreset ex_imm", ex_imm, 32'd0);
    check("midreset ex_reg_write", 32'(ex_reg_write), 32'd0);
    check("midreset bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("midreset pc_write", 32'(pc_write), 32'd1);
    check("midreset ifid_write", 32'(ifid_write), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_stall = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset ex_rt", 32'(ex_rt), 32'd13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
